// File: rtl/gclken_pkg.sv
// Shared types and defaults for the gated clock-enable generator.
package gclken_pkg;

    localparam int unsigned GCLKEN_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } gclken_state_e;

endpackage

// File: rtl/gclken_cnt.sv
// Period down-counter: loads on request, reloads from i_val on reaching zero while running.
module gclken_cnt
    import gclken_pkg::*;
#(
    parameter int unsigned W = GCLKEN_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_run,
    input  logic [W-1:0] i_val,
    output logic         o_zero_c,
    output logic         o_nxt_zero_c
);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_load || (i_run && (r_cnt == '0))) begin
            w_cnt_nxt = i_val;
        end else if (i_run) begin
            w_cnt_nxt = r_cnt - W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_zero_c     = (r_cnt == '0);
    // Lets the parent register its pulse output one cycle ahead.
    assign o_nxt_zero_c = (w_cnt_nxt == '0);

endmodule

// File: rtl/gclken_gen.sv
// Clock-enable generator: one-cycle Z pulse every DIV+1 cycles with
// glitch-free ratio changes adopted only at period boundaries.
module gclken_gen
    import gclken_pkg::*;
#(
    parameter int unsigned W        = GCLKEN_W,
    parameter int unsigned INIT_DIV = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] DIV,
    input  logic         LD,
    output logic         ACK,
    output logic         Z,
    output logic         BUSY
);

    gclken_state_e r_state;
    gclken_state_e w_state_nxt;
    logic [W-1:0]  r_ratio;
    logic [W-1:0]  w_ratio_nxt;
    logic          r_ack;
    logic          w_ack_nxt;
    logic          r_ld_blk;
    logic          r_z;
    logic          r_busy;

    logic          w_req;
    logic          w_cnt_load;
    logic          w_cnt_run;
    logic [W-1:0]  w_cnt_val;
    logic          w_cnt_zero;
    logic          w_cnt_nxt_zero;

    // A held LD is blocked from the adoption edge until it is seen low.
    assign w_req = LD & ~r_ld_blk;

    gclken_cnt #(
        .W (W)
    ) u_cnt (
        .i_clk        (CLK),
        .i_rst        (RST),
        .i_load       (w_cnt_load),
        .i_run        (w_cnt_run),
        .i_val        (w_cnt_val),
        .o_zero_c     (w_cnt_zero),
        .o_nxt_zero_c (w_cnt_nxt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ratio_nxt = r_ratio;
        w_ack_nxt   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_run   = 1'b0;
        w_cnt_val   = r_ratio;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_ratio_nxt = DIV;
                    w_ack_nxt   = 1'b1;
                end
                if (EN) begin
                    w_state_nxt = RUN;
                    w_cnt_load  = 1'b1;
                    w_cnt_val   = w_ratio_nxt;
                end
            end
            RUN, STOP: begin
                w_cnt_run = 1'b1;
                // Ratio changes land only on the terminal cycle of a period.
                if (w_cnt_zero && w_req) begin
                    w_ratio_nxt = DIV;
                    w_cnt_val   = DIV;
                    w_ack_nxt   = 1'b1;
                end
                if (r_state == RUN) begin
                    if (!EN) begin
                        w_state_nxt = STOP;
                    end
                end else if (EN) begin
                    w_state_nxt = RUN;
                end else if (w_cnt_zero) begin
                    w_state_nxt = IDLE;
                    w_cnt_run   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_ratio  <= W'(INIT_DIV);
            r_ack    <= 1'b0;
            r_ld_blk <= 1'b0;
            r_z      <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ratio  <= w_ratio_nxt;
            r_ack    <= w_ack_nxt;
            r_ld_blk <= w_ack_nxt | (r_ld_blk & LD);
            r_z      <= (w_state_nxt != IDLE) & w_cnt_nxt_zero;
            r_busy   <= (w_state_nxt != IDLE);
        end
    end

    assign ACK  = r_ack;
    assign Z    = r_z;
    assign BUSY = r_busy;

endmodule

// File: tb/tb_gclken_gen.sv
// Bench for gclken_gen: directed scenarios plus randomized run against a period-level model.
module tb_gclken_gen;

    localparam int unsigned W        = 8;
    localparam int unsigned INIT_DIV = 1;

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic         LD;
    logic [W-1:0] DIV;
    logic         ACK;
    logic         Z;
    logic         BUSY;

    int vectors     = 0;
    int miscompares = 0;

    // Model: mode 0 idle / 1 run / 2 stop, m_left = cycles left in period incl. current.
    int m_mode;
    int m_left;
    int m_ratio;
    bit m_blk;
    bit m_ack;

    gclken_gen #(
        .W        (W),
        .INIT_DIV (INIT_DIV)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .EN   (EN),
        .DIV  (DIV),
        .LD   (LD),
        .ACK  (ACK),
        .Z    (Z),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    function automatic void model_edge();
        bit req;
        bit zc;
        bit adopt;
        if (RST) begin
            m_mode  = 0;
            m_left  = 0;
            m_ratio = INIT_DIV;
            m_blk   = 1'b0;
            m_ack   = 1'b0;
            return;
        end
        req   = LD && !m_blk;
        zc    = (m_mode != 0) && (m_left == 1);
        adopt = req && ((m_mode == 0) || zc);
        if (adopt) m_ratio = int'(DIV);
        if (m_mode == 0) begin
            if (EN) begin
                m_mode = 1;
                m_left = m_ratio + 1;
            end
        end else begin
            m_left = zc ? m_ratio + 1 : m_left - 1;
            if (m_mode == 1 && !EN)      m_mode = 2;
            else if (m_mode == 2 && EN)  m_mode = 1;
            else if (m_mode == 2 && zc)  m_mode = 0;
        end
        m_blk = adopt || (m_blk && LD);
        m_ack = adopt;
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; EN = 1'b0; LD = 1'b0; DIV = '0;
        tick();
        RST = 1'b0;
    endtask

    task automatic load_idle(input int d);
        LD = 1'b1; DIV = W'(d);
        tick();
        LD = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [2:0] got;
        RST = 1'b1; EN = 1'b1; LD = 1'b1; DIV = 8'd5;
        tick();
        got = {Z, ACK, BUSY};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_dominant {Z,ACK,BUSY} got %b want 000", got);
        end
        RST = 1'b0; EN = 1'b0; LD = 1'b0;
        tick();
        got = {Z, ACK, BUSY};
        vectors++;
        if (got !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_idle {Z,ACK,BUSY} got %b want 000", got);
        end
    endtask

    task automatic test_init_div();
        logic [2:0] got, exp;
        do_reset();
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k % 2) == 0, 1'b0, 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL init_div k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_ratio_change();
        logic [2:0] got, exp;
        do_reset();
        load_idle(3);
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 14; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k == 4) || (k >= 8), k == 9, 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ratio_change k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            LD = (k >= 5) && (k <= 8);
            DIV = '0;
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_stop();
        logic [2:0] got, exp;
        do_reset();
        load_idle(4);
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 12; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k == 5) || (k == 10), 1'b0, k <= 10};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stop k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            EN = (k < 7);
            tick();
        end
    endtask

    task automatic test_stop_resume();
        logic [2:0] got, exp;
        do_reset();
        load_idle(4);
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 26; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k % 5) == 0, 1'b0, 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL stop_resume k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            EN = !((k == 7) || ((k >= 12) && (k <= 14)) || (k == 20));
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [2:0] got, exp;
        do_reset();
        load_idle(7);
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 13; k++) begin
            got = {Z, ACK, BUSY};
            exp = {k == 8, 1'b0, k <= 11};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_abort k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            LD  = (k >= 10) && (k <= 11);
            DIV = 8'd2;
            RST = (k == 11);
            EN  = (k <= 11);
            tick();
        end
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 4; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k % 2) == 0, 1'b0, 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL reset_ratio k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_en_ld_together();
        logic [2:0] got, exp;
        do_reset();
        EN = 1'b1; LD = 1'b1; DIV = 8'd2;
        tick();
        for (int k = 1; k <= 10; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k % 3) == 0, k == 1, 1'b1};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL en_ld_together k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            LD = 1'b0;
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_ld_stop_idle();
        logic [2:0] got, exp;
        do_reset();
        EN = 1'b1;
        tick();
        for (int k = 1; k <= 10; k++) begin
            got = {Z, ACK, BUSY};
            exp = {(k == 2) || (k == 9), k == 3, k != 3};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ld_stop_idle k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            if (k == 1) EN = 1'b0;
            if (k == 2) begin LD = 1'b1; DIV = 8'd5; end
            if (k == 3) begin LD = 1'b0; EN = 1'b1; end
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_ld_hold();
        logic [2:0] got, exp;
        do_reset();
        LD = 1'b1; DIV = 8'd3;
        tick();
        for (int k = 1; k <= 7; k++) begin
            got = {Z, ACK, BUSY};
            exp = {k >= 6, (k == 1) || (k == 5), k >= 6};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL ld_hold k=%0d {Z,ACK,BUSY} got %b want %b", k, got, exp);
            end
            LD = (k <= 2) || (k == 4);
            if (k == 4) DIV = '0;
            EN = (k >= 5);
            tick();
        end
        EN = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0] got, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            got = {Z, ACK, BUSY};
            exp = {(m_mode != 0) && (m_left == 1), m_ack, m_mode != 0};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL random i=%0d {Z,ACK,BUSY} got %b want %b", i, got, exp);
            end
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) EN = ~EN;
            if (LD) begin
                if (m_blk && ($urandom_range(0, 2) != 0)) LD = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                LD  = 1'b1;
                DIV = W'($urandom_range(0, 5));
            end
            tick();
        end
        RST = 1'b0; EN = 1'b0; LD = 1'b0;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; LD = 1'b0; DIV = '0;
        test_reset();
        test_init_div();
        test_ratio_change();
        test_stop();
        test_stop_resume();
        test_reset_abort();
        test_en_ld_together();
        test_ld_stop_idle();
        test_ld_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
